// File: rtl/video_timing.sv
`default_nettype none
// ============================================================================
// Module   : video_timing
// Purpose  : Raster timing generator: signed hpos/vpos, sync, de, line/frame
//            strobes. Optional frame counter under VIDEO_TIMING_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing #(
   parameter int   HRES   = 1280,
   parameter int   HFP    = 110,
   parameter int   HSW    = 40,
   parameter int   HBP    = 220,
   parameter int   VRES   = 720,
   parameter int   VFP    = 5,
   parameter int   VSW    = 5,
   parameter int   VBP    = 20,
   parameter logic HS_POL = 1'b1,
   parameter logic VS_POL = 1'b1
) (
   input  logic               pixel_clk,
   input  logic               rst,
   output logic signed [11:0] hpos,
   output logic signed [11:0] vpos,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic               lsync,
   output logic               fsync
`ifdef VIDEO_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]        frame_cnt
`endif
);

   localparam int H_BLANK = HFP + HSW + HBP;
   localparam int V_BLANK = VFP + VSW + VBP;

   localparam logic signed [11:0] H_START = 12'(-H_BLANK);
   localparam logic signed [11:0] H_LAST  = 12'(HRES - 1);
   localparam logic signed [11:0] HS_BEG  = 12'(HFP - H_BLANK);
   localparam logic signed [11:0] HS_END  = 12'(HFP + HSW - H_BLANK);
   localparam logic signed [11:0] V_START = 12'(-V_BLANK);
   localparam logic signed [11:0] V_LAST  = 12'(VRES - 1);
   localparam logic signed [11:0] VS_BEG  = 12'(VFP - V_BLANK);
   localparam logic signed [11:0] VS_END  = 12'(VFP + VSW - V_BLANK);

   logic signed [11:0] h_next;
   logic signed [11:0] v_next;
   logic               h_wrap;
   logic               line_start;
   logic               frame_start;

   // Flags are derived from the next position so they register alongside it.
   always_comb begin
      h_wrap      = (hpos == H_LAST);
      h_next      = h_wrap ? H_START : hpos + 12'sd1;
      v_next      = vpos;
      if (h_wrap) begin
         v_next = (vpos == V_LAST) ? V_START : vpos + 12'sd1;
      end
      line_start  = (h_next == H_START);
      frame_start = line_start && (v_next == V_START);
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         hpos      <= H_LAST;
         vpos      <= V_LAST;
         hsync     <= ~HS_POL;
         vsync     <= ~VS_POL;
         de        <= 1'b0;
         lsync     <= 1'b0;
         fsync     <= 1'b0;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
         frame_cnt <= 16'd0;
`endif
      end else begin
         hpos  <= h_next;
         vpos  <= v_next;
         hsync <= ((h_next >= HS_BEG) && (h_next < HS_END)) ? HS_POL : ~HS_POL;
         vsync <= ((v_next >= VS_BEG) && (v_next < VS_END)) ? VS_POL : ~VS_POL;
         de    <= (h_next >= 12'sd0) && (v_next >= 12'sd0);
         lsync <= line_start;
         fsync <= frame_start;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
         if (frame_start) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_video_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing
// Purpose  : Self-checking bench for video_timing on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing;

   localparam int   HRES = 20, HFP = 3, HSW = 4, HBP = 5;
   localparam int   VRES = 12, VFP = 2, VSW = 3, VBP = 4;
   localparam logic HS_POL = 1'b1;
   localparam logic VS_POL = 1'b0;
   localparam int   H_BLANK = HFP + HSW + HBP;        // 12
   localparam int   V_BLANK = VFP + VSW + VBP;        // 9
   localparam int   LINE    = HRES + H_BLANK;         // 32
   localparam int   FLINES  = VRES + V_BLANK;         // 21
   localparam int   FRAME   = LINE * FLINES;          // 672

   logic               pixel_clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [11:0] hpos, vpos;
   logic               hsync, vsync, de, lsync, fsync;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
   logic [15:0]        frame_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   video_timing #(
      .HRES(HRES), .HFP(HFP), .HSW(HSW), .HBP(HBP),
      .VRES(VRES), .VFP(VFP), .VSW(VSW), .VBP(VBP),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) dut (
      .pixel_clk(pixel_clk),
      .rst(rst),
      .hpos(hpos),
      .vpos(vpos),
      .hsync(hsync),
      .vsync(vsync),
      .de(de),
      .lsync(lsync),
      .fsync(fsync)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      ,
      .frame_cnt(frame_cnt)
`endif
   );

   always #5 pixel_clk = ~pixel_clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: outputs are a pure function of cycles elapsed since reset release.
   bit m_rst   = 1'b1;
   int m_t     = 0;
   bit started = 1'b0;

   always @(posedge pixel_clk) begin
      started <= 1'b1;
      if (rst) begin
         m_rst <= 1'b1;
         m_t   <= 0;
      end else if (m_rst) begin
         m_rst <= 1'b0;
         m_t   <= 0;
      end else begin
         m_t <= m_t + 1;
      end
   end

   always @(negedge pixel_clk) begin
      if (started) begin
         int px, ln, eh, ev, ehs, evs, ede, els, efs, efc;
         if (m_rst) begin
            eh = HRES - 1; ev = VRES - 1;
            ehs = int'(!HS_POL); evs = int'(!VS_POL);
            ede = 0; els = 0; efs = 0; efc = 0;
         end else begin
            px  = m_t % LINE;
            ln  = (m_t / LINE) % FLINES;
            eh  = px - H_BLANK;
            ev  = ln - V_BLANK;
            ehs = (px >= HFP && px < HFP + HSW) ? int'(HS_POL) : int'(!HS_POL);
            evs = (ln >= VFP && ln < VFP + VSW) ? int'(VS_POL) : int'(!VS_POL);
            ede = (px >= H_BLANK && ln >= V_BLANK) ? 1 : 0;
            els = (px == 0) ? 1 : 0;
            efs = (px == 0 && ln == 0) ? 1 : 0;
            efc = ((m_t / FRAME) + 1) % 65536;
         end
         chk("hpos",  int'(hpos), eh);
         chk("vpos",  int'(vpos), ev);
         chk("hsync", int'(hsync), ehs);
         chk("vsync", int'(vsync), evs);
         chk("de",    int'(de), ede);
         chk("lsync", int'(lsync), els);
         chk("fsync", int'(fsync), efs);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
         chk("frame_cnt", int'(frame_cnt), efc);
`endif
      end
   end

   // Waits (bounded) for the next fsync; returns cycles taken and per-signal tallies.
   task automatic measure_frame(output int cyc, output int n_de, output int n_hs,
                                output int n_vs, output int n_ls);
      cyc = 0; n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0;
      do begin
         n_de += int'(de);
         n_hs += int'(hsync == HS_POL);
         n_vs += int'(vsync == VS_POL);
         n_ls += int'(lsync);
         @(negedge pixel_clk);
         cyc++;
      end while (!fsync && cyc < 2 * FRAME);
   endtask

   initial begin
      int cyc, n_de, n_hs, n_vs, n_ls, guard;

      rst = 1'b1;
      repeat (10) @(negedge pixel_clk);
      chk("rst_hpos",  int'(hpos), 19);
      chk("rst_vpos",  int'(vpos), 11);
      chk("rst_de",    int'(de), 0);
      chk("rst_fsync", int'(fsync), 0);
      chk("rst_hsync", int'(hsync), 0);
      chk("rst_vsync", int'(vsync), 1);

      rst = 1'b0;
      @(negedge pixel_clk);
      chk("first_hpos",  int'(hpos), -12);
      chk("first_vpos",  int'(vpos), -9);
      chk("first_fsync", int'(fsync), 1);
      chk("first_lsync", int'(lsync), 1);
      @(negedge pixel_clk);
      chk("second_fsync", int'(fsync), 0);
      chk("second_hpos",  int'(hpos), -11);

      // Frame cadence and per-frame tallies over two consecutive frames.
      guard = 0;
      while (!fsync && guard < 2 * FRAME) begin @(negedge pixel_clk); guard++; end
      chk("fsync_found", int'(fsync), 1);
      for (int f = 0; f < 2; f++) begin
         measure_frame(cyc, n_de, n_hs, n_vs, n_ls);
         chk("frame_period", cyc, 672);
         chk("de_per_frame", n_de, 240);
         chk("hsync_per_frame", n_hs, 84);
         chk("vsync_per_frame", n_vs, 96);
         chk("lsync_per_frame", n_ls, 21);
      end

      // Mid-frame reset at a fixed active position.
      guard = 0;
      while (!(hpos == 12'sd5 && vpos == 12'sd6) && guard < 2 * FRAME) begin
         @(negedge pixel_clk); guard++;
      end
      chk("midframe_pos_found", int'(hpos == 12'sd5 && vpos == 12'sd6), 1);
      rst = 1'b1;
      repeat (2) @(negedge pixel_clk);
      chk("mid_rst_hpos",  int'(hpos), 19);
      chk("mid_rst_vpos",  int'(vpos), 11);
      chk("mid_rst_fsync", int'(fsync), 0);
      rst = 1'b0;
      @(negedge pixel_clk);
      chk("mid_post_fsync", int'(fsync), 1);
      chk("mid_post_hpos",  int'(hpos), -12);

      // Random run lengths and reset pulses; the reference model checks every cycle.
      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(1500, 30)) @(negedge pixel_clk);
         rst = 1'b1;
         repeat ($urandom_range(3, 1)) @(negedge pixel_clk);
         rst = 1'b0;
      end
      repeat (FRAME + 50) @(negedge pixel_clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_timing.md
# video_timing

Raster timing generator for the HDMI video path. Free-running horizontal/vertical counters on `pixel_clk` produce signed `hpos`/`vpos`, sync pulses, data-enable and the once-per-frame `fsync` strobe. Sits directly upstream of every sprite block (paddles, ball) and the HDMI encoder. Sprite blocks compare against `hpos`/`vpos` and update their motion on `fsync`.

## Interface
Reset is synchronous and active-high. One clock: `pixel_clk`, reset `rst`.

Parameters:
- `HRES`, 1280, active pixels per line
- `HFP`, 110, horizontal front porch (pixels)
- `HSW`, 40, hsync width (pixels)
- `HBP`, 220, horizontal back porch (pixels)
- `VRES`, 720, active lines per frame
- `VFP`, 5, vertical front porch (lines)
- `VSW`, 5, vsync width (lines)
- `VBP`, 20, vertical back porch (lines)
- `HS_POL`, 1, hsync active level
- `VS_POL`, 1, vsync active level

Ports:
- `pixel_clk`, in, 1, pixel clock
- `rst`, in, 1, synchronous active-high reset
- `hpos`, out, 12 signed, horizontal position; negative in blanking, 0..HRES-1 active
- `vpos`, out, 12 signed, vertical position; negative in blanking, 0..VRES-1 active
- `hsync`, out, 1, horizontal sync, polarity `HS_POL`
- `vsync`, out, 1, vertical sync, polarity `VS_POL`
- `de`, out, 1, data enable (active video)
- `lsync`, out, 1, one-cycle strobe at start of each line
- `fsync`, out, 1, one-cycle strobe at start of each frame
- `frame_cnt`, out, 16, frame counter (only with `VIDEO_TIMING_FRAME_CNT_EN`)

## Operation
- Derived: `H_START = -(HFP+HSW+HBP)` (-370), `V_START = -(VFP+VSW+VBP)` (-30).
- `hpos` counts `H_START`..`HRES-1`, step 1 per clock. At `HRES-1` it wraps to `H_START`, and `vpos` steps by 1. `vpos` wraps `VRES-1` to `V_START`.
- Horizontal blanking order from `H_START`: front porch, sync, back porch. hsync is active for `H_START+HFP <= hpos < H_START+HFP+HSW` (-260..-221).
- vsync uses the same rule on `vpos`: active for -25..-21. It is line-aligned, changing with the `hpos` wrap.
- `de = (hpos >= 0) && (vpos >= 0)`.
- `lsync = (hpos == H_START)`.
- `fsync = (hpos == H_START) && (vpos == V_START)`. It occurs at the start of vertical blanking, giving sprites the full blanking interval to update.
- All outputs are registered in one always block. Flags are always coherent with the `hpos`/`vpos` values presented in the same cycle.
- Counters use 12-bit signed arithmetic. Legal configurations require `HRES <= 2047`, `HFP+HSW+HBP <= 2048`, and likewise vertically; no saturation logic.

## Timing
- Reset values while `rst` is high:
  - `hpos = HRES-1`, `vpos = VRES-1`.
  - `de = 0`, `lsync = 0`, `fsync = 0`.
  - `hsync = !HS_POL`, `vsync = !VS_POL`.
  - `frame_cnt = 0`.
- On the first rising edge with `rst` low: `hpos = H_START`, `vpos = V_START`, `fsync = 1`, `lsync = 1`. The frame starts immediately; there is no partial frame.
- Line period is `HRES+HFP+HSW+HBP` = 1650 clocks.
- Frame period is 1650 × 750 = 1,237,500 clocks between `fsync` pulses.
- `fsync` and `lsync` are high for exactly 1 cycle each.
- Reset mid-frame takes effect on the next edge and aborts the frame; no `fsync` is issued during reset.
- Output latency: zero cycles between an output position and its flags (coherent); one cycle from reset release to the first position.

## Configuration
- `VIDEO_TIMING_FRAME_CNT_EN` defined:
  - `frame_cnt` port exists; reset to 0.
  - Increments by 1 in the same cycle `fsync` is asserted, so the first frame after reset reads 1.
  - Wraps 0xFFFF to 0x0000.
- Undefined: the port and its register are absent; all other behaviour is identical.

## Test plan
- Reset values: hold `rst` high 10 cycles -> `hpos = 1279`, `vpos = 719`, `de = 0`, `fsync = 0`, `hsync = 0`, `vsync = 0`.
- First frame: release `rst` -> next cycle `hpos = -370`, `vpos = -30`, `fsync = lsync = 1`. The following cycle `fsync = 0`, `hpos = -369`.
- Line and sync windows: over one line, `hsync` is high for exactly 40 cycles starting at `hpos = -260`. `de` is high for exactly 1280 cycles on active lines, 0 on blank lines. `lsync` period is 1650.
- Frame cadence: 3 consecutive `fsync` pulses are exactly 1,237,500 cycles apart.
  - `de` totals 921,600 cycles per frame.
  - `vsync` is high for 5 lines starting at `vpos = -25`.
- Mid-frame reset: assert `rst` at `hpos = 100`, `vpos = 300` for 2 cycles -> reset values appear, then `fsync` on the first post-reset cycle.
  - With `VIDEO_TIMING_FRAME_CNT_EN`: `frame_cnt` reads 1 after the first post-reset `fsync`. Force the counter to 0xFFFF and run one frame -> it reads 0x0000.
